lzx_74hc153: RTL and testbench
==============================

Name: lzx_74hc153

Overview:
- Dual 4-input multiplexer modelled on the 74HC153, with registered outputs.
- Two sections share one select bus `S`; each section has its own active-low enable.
- Used as a clocked glue-logic selector in the gate-library designs.
- Outputs update on the rising clock edge, one cycle after the inputs are presented.

Parameters:
- REG_OUT, 1, when 1 `Y1`/`Y2` are registered (1-cycle latency); when 0 they are purely combinational and `clk`/`rst` have no effect on them.

Ports:
- clk   input  1  system clock, rising-edge active
- rst   input  1  synchronous, active-high reset
- E1_n  input  1  section 1 enable, active low
- E2_n  input  1  section 2 enable, active low
- S     input  2  common select; S[1] is MSB, S[0] is LSB
- D1    input  4  section 1 data inputs; D1[i] is selected when S==i
- D2    input  4  section 2 data inputs; D2[i] is selected when S==i
- Y1    output 1  section 1 output (true, non-inverted)
- Y2    output 1  section 2 output (true, non-inverted)

Behaviour:
- Combinational next-value, section n (n = 1, 2):
  - If `En_n`==1: next Yn = 0.
  - Else: next Yn = Dn[S].
- Select decode:
  - S=00 selects D[0]; S=01 selects D[1]; S=10 selects D[2]; S=11 selects D[3].
  - Decode is shared by both sections.
- Section independence: E1_n affects only Y1; E2_n affects only Y2. The two sections never interact apart from sharing `S`.
- REG_OUT=1:
  - On each rising `clk`, Y1/Y2 load their next-values.
  - Latency is exactly 1 cycle from any input change to the output.
  - Outputs hold between edges; no glitches are visible at the outputs.
- Reset (`rst`), REG_OUT=1:
  - Sampled only on the rising `clk`; it has no asynchronous effect.
  - While `rst`=1 at an edge, Y1=0 and Y2=0 regardless of other inputs.
  - Reset has priority over the enables and data.
  - Reset asserted mid-operation clears the outputs at the next edge.
  - The first edge after `rst` deasserts loads the normal next-values.
- Power-up: outputs are undefined until the first reset edge. The bench must apply reset first.
- REG_OUT=0: Y1/Y2 follow the next-value equations combinationally. `rst` and `clk` are ignored.
- Undefined inputs: X/Z on the selected data bit or on the enable propagates as X to the output. The bench drives only 0/1 values.
- Structure: implementation is fully synchronous, single clock domain. No latches and no internal state beyond the two output flops.

Test Plan:
- Reset: `rst`=1 for 2 cycles with E1_n=0, E2_n=0, S=00, D1=1111, D2=1111 -> Y1=0, Y2=0. Deassert `rst` -> Y1=1, Y2=1 one edge later.
- Enable off: E1_n=1, E2_n=0, S=00, D1=1111, D2=0000 -> Y1=0 (disabled despite D1[0]=1), Y2=0.
- Select 0 and data tracking (E1_n=0, S=00):
  - D1=1110 -> Y1=0 after 1 edge.
  - Then D1=1111 -> Y1=1 after 1 edge.
- Select 1: S=01, D1=1101 -> Y1=0. Then D1=0010 -> Y1=1. Other bits of D1 have no effect.
- Section 2, select 3: E2_n=0, S=11, D2=1000 -> Y2=1, with Y1 still equal to D1[3] independently. Then E2_n=1 -> Y2=0 next edge.
- Exhaustive sweep: all 4 S values × both enable states × walking-one/walking-zero patterns on D1/D2.
  - Compare against the reference equation with 1-cycle delay.
  - Repeat with REG_OUT=0 for zero-latency equivalence.

Source files
------------

// File: rtl/lzx_74hc153.sv
// Dual 4-input multiplexer after the 74HC153.
// Shared select, per-section active-low enables, optional output register.
module lzx_74hc153 #(
  parameter bit REG_OUT = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       E1_n,
  input  logic       E2_n,
  input  logic [1:0] S,
  input  logic [3:0] D1,
  input  logic [3:0] D2,
  output logic       Y1,
  output logic       Y2
);

  logic [3:0] sel;
  logic       nxt1;
  logic       nxt2;

  // One-hot select decode shared by both sections.
  always_comb begin
    sel = 4'b0000;
    unique case (1'b1)
      (S == 2'd0): sel = 4'b0001;
      (S == 2'd1): sel = 4'b0010;
      (S == 2'd2): sel = 4'b0100;
      (S == 2'd3): sel = 4'b1000;
      default:     sel = 4'b0000;
    endcase
  end

  always_comb begin
    nxt1 = ~E1_n & (|(D1 & sel));
    nxt2 = ~E2_n & (|(D2 & sel));
  end

  generate
    if (REG_OUT) begin : g_reg
      always_ff @(posedge clk) begin
        if (rst) begin
          Y1 <= 1'b0;
          Y2 <= 1'b0;
        end else begin
          Y1 <= nxt1;
          Y2 <= nxt2;
        end
      end
    end else begin : g_comb
      assign Y1 = nxt1;
      assign Y2 = nxt2;
    end
  endgenerate

endmodule

// File: tb/tb_lzx_74hc153.sv
// Bench for lzx_74hc153: registered and combinational builds side by side.
// Random and directed stimulus against a shift-based reference.
module tb_lzx_74hc153;

  logic       clk = 1'b0;
  logic       rst;
  logic       e1_n;
  logic       e2_n;
  logic [1:0] s;
  logic [3:0] d1;
  logic [3:0] d2;
  logic       ya1;
  logic       ya2;
  logic       yc1;
  logic       yc2;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  lzx_74hc153 #(.REG_OUT(1'b1)) dut_r (
    .clk(clk), .rst(rst),
    .E1_n(e1_n), .E2_n(e2_n),
    .S(s), .D1(d1), .D2(d2),
    .Y1(ya1), .Y2(ya2)
  );

  lzx_74hc153 #(.REG_OUT(1'b0)) dut_c (
    .clk(clk), .rst(rst),
    .E1_n(e1_n), .E2_n(e2_n),
    .S(s), .D1(d1), .D2(d2),
    .Y1(yc1), .Y2(yc2)
  );

  function automatic logic model(input logic en_n,
                                 input int sv,
                                 input int dv);
    if (en_n) return 1'b0;
    return 1'((dv >> sv) & 1);
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic a, input logic b,
                       input logic [1:0] sv,
                       input logic [3:0] x1,
                       input logic [3:0] x2);
    e1_n = a;
    e2_n = b;
    s = sv;
    d1 = x1;
    d2 = x2;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 2'd0, 4'hF, 4'hF);
    for (int i = 0; i < 2; i++) begin
      cycle();
      total++;
      if (ya1 !== 1'b0 || ya2 !== 1'b0) begin
        bad++;
        $display("FAIL reset_hold: got %b%b want 00", ya1, ya2);
      end
      total++;
      if (yc1 !== 1'b1 || yc2 !== 1'b1) begin
        bad++;
        $display("FAIL reset_comb_ignores: got %b%b want 11",
                 yc1, yc2);
      end
    end
    rst = 1'b0;
    cycle();
    total++;
    if (ya1 !== 1'b1 || ya2 !== 1'b1) begin
      bad++;
      $display("FAIL reset_release: got %b%b want 11", ya1, ya2);
    end
  endtask

  task automatic test_enable_off();
    drive(1'b1, 1'b0, 2'd0, 4'hF, 4'h0);
    cycle();
    total++;
    if (ya1 !== 1'b0 || ya2 !== 1'b0) begin
      bad++;
      $display("FAIL enable_off: got %b%b want 00", ya1, ya2);
    end
  endtask

  task automatic test_select0();
    drive(1'b0, 1'b0, 2'd0, 4'b1110, 4'h0);
    cycle();
    total++;
    if (ya1 !== 1'b0) begin
      bad++;
      $display("FAIL sel0_low: got %b want 0", ya1);
    end
    d1 = 4'b1111;
    #1;
    total++;
    if (ya1 !== 1'b0) begin
      bad++;
      $display("FAIL sel0_latency: got %b want 0", ya1);
    end
    cycle();
    total++;
    if (ya1 !== 1'b1) begin
      bad++;
      $display("FAIL sel0_high: got %b want 1", ya1);
    end
  endtask

  task automatic test_select1();
    drive(1'b0, 1'b0, 2'd1, 4'b1101, 4'h0);
    cycle();
    total++;
    if (ya1 !== 1'b0) begin
      bad++;
      $display("FAIL sel1_low: got %b want 0", ya1);
    end
    d1 = 4'b0010;
    cycle();
    total++;
    if (ya1 !== 1'b1) begin
      bad++;
      $display("FAIL sel1_high: got %b want 1", ya1);
    end
  endtask

  task automatic test_section2();
    drive(1'b0, 1'b0, 2'd3, 4'b0111, 4'b1000);
    cycle();
    total++;
    if (ya2 !== 1'b1 || ya1 !== 1'b0) begin
      bad++;
      $display("FAIL sec2_sel3: got y1=%b y2=%b want 0 1",
               ya1, ya2);
    end
    e2_n = 1'b1;
    d1 = 4'b1000;
    cycle();
    total++;
    if (ya2 !== 1'b0 || ya1 !== 1'b1) begin
      bad++;
      $display("FAIL sec2_disable: got y1=%b y2=%b want 1 0",
               ya1, ya2);
    end
  endtask

  task automatic test_sweep();
    logic [3:0] pat [8];
    logic x1;
    logic x2;
    for (int k = 0; k < 4; k++) begin
      pat[k] = 4'(1 << k);
      pat[k + 4] = ~(4'(1 << k));
    end
    for (int sv = 0; sv < 4; sv++) begin
      for (int e = 0; e < 4; e++) begin
        for (int k = 0; k < 8; k++) begin
          drive(e[0], e[1], 2'(sv), pat[k], pat[(k + 3) % 8]);
          x1 = model(e[0], sv, int'(pat[k]));
          x2 = model(e[1], sv, int'(pat[(k + 3) % 8]));
          #1;
          total++;
          if (yc1 !== x1 || yc2 !== x2) begin
            bad++;
            $display("FAIL sweep_comb s=%0d e=%0d k=%0d: got %b%b want %b%b",
                     sv, e, k, yc1, yc2, x1, x2);
          end
          cycle();
          total++;
          if (ya1 !== x1 || ya2 !== x2) begin
            bad++;
            $display("FAIL sweep_reg s=%0d e=%0d k=%0d: got %b%b want %b%b",
                     sv, e, k, ya1, ya2, x1, x2);
          end
        end
      end
    end
  endtask

  task automatic test_random();
    logic x1;
    logic x2;
    for (int i = 0; i < 300; i++) begin
      rst = ($urandom_range(0, 9) == 0);
      drive(1'($urandom), 1'($urandom), 2'($urandom),
            4'($urandom), 4'($urandom));
      x1 = rst ? 1'b0 : model(e1_n, int'(s), int'(d1));
      x2 = rst ? 1'b0 : model(e2_n, int'(s), int'(d2));
      cycle();
      total++;
      if (ya1 !== x1 || ya2 !== x2) begin
        bad++;
        $display("FAIL random_reg i=%0d: got %b%b want %b%b",
                 i, ya1, ya2, x1, x2);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [1:0] prev1;
    drive(1'b0, 1'b0, 2'd2, 4'b0100, 4'b0100);
    cycle();
    prev1 = {ya1, ya2};
    d1 = 4'b0000;
    d2 = 4'b1011;
    rst = 1'b1;
    #1;
    total++;
    if ({ya1, ya2} !== prev1 || prev1 !== 2'b11) begin
      bad++;
      $display("FAIL reset_sync: got %b%b want 11", ya1, ya2);
    end
    cycle();
    total++;
    if (ya1 !== 1'b0 || ya2 !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid: got %b%b want 00", ya1, ya2);
    end
    rst = 1'b0;
    d1 = 4'b0100;
    d2 = 4'b0000;
    cycle();
    total++;
    if (ya1 !== 1'b1 || ya2 !== 1'b0) begin
      bad++;
      $display("FAIL after_reset: got %b%b want 10", ya1, ya2);
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b1, 1'b1, 2'd0, 4'h0, 4'h0);
    test_reset();
    test_enable_off();
    test_select0();
    test_select1();
    test_section2();
    test_sweep();
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
